// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ts_pkg
// Brief    : Shared constants and FSM state type for the TS stream checker.
// Revision : 1.0 - initial release
// ============================================================================
package ts_pkg;

   localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
   localparam int          TS_PKT_LEN   = 188;
   localparam logic [12:0] TS_NULL_PID  = 13'h1FFF;
   localparam logic [7:0]  TS_LAST_IDX  = 8'(TS_PKT_LEN - 1);

   typedef enum logic [1:0] {
      HUNT      = 2'd0,
      IN_PKT    = 2'd1,
      WAIT_SYNC = 2'd2
   } ts_state_t;

endpackage
`default_nettype wire

// File: rtl/ts_cc_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ts_cc_tracker
// Brief    : Per-channel continuity-counter check plus packet/CC-error stats.
// Revision : 1.0 - initial release
// ============================================================================
module ts_cc_tracker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_check,
   input  logic [1:0]       i_ch,
   input  logic             i_afc0,
   input  logic [3:0]       i_cc,
   input  logic [1:0]       i_sel,
   output logic             o_cc_err,
   output logic [CNT_W-1:0] o_pkt_cnt,
   output logic [CNT_W-1:0] o_cc_err_cnt
);

   logic [3:0]       r_seen;
   logic [3:0]       r_last_cc [4];
   logic             r_cc_err;
   logic             r_hit;
   logic [1:0]       r_hit_ch;
   logic [CNT_W-1:0] w_pkt_cnt [4];
   logic [CNT_W-1:0] w_cc_cnt  [4];
   logic [3:0]       w_prev_cc;
   logic [3:0]       w_exp_cc;
   logic             w_mismatch;

   // Adaptation-only packets repeat the previous CC.
   assign w_prev_cc  = r_last_cc[i_ch];
   assign w_exp_cc   = i_afc0 ? w_prev_cc + 4'd1 : w_prev_cc;
   assign w_mismatch = i_check && r_seen[i_ch] && (i_cc != w_exp_cc);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_seen   <= '0;
         r_cc_err <= 1'b0;
         r_hit    <= 1'b0;
         r_hit_ch <= '0;
         for (int k = 0; k < 4; k++) r_last_cc[k] <= '0;
      end else begin
         r_cc_err <= w_mismatch;
         r_hit    <= i_check;
         r_hit_ch <= i_ch;
         if (i_check) begin
            r_seen[i_ch]    <= 1'b1;
            r_last_cc[i_ch] <= i_cc;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         localparam logic [1:0] c_ch = 2'(gi);
         logic [CNT_W-1:0] r_pkt_cnt;
         logic [CNT_W-1:0] r_cc_cnt;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_pkt_cnt <= '0;
               r_cc_cnt  <= '0;
            end else if (r_hit && (r_hit_ch == c_ch)) begin
               if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
               if (r_cc_err && (r_cc_cnt != '1)) r_cc_cnt <= r_cc_cnt + CNT_W'(1);
            end
         end

         assign w_pkt_cnt[gi] = r_pkt_cnt;
         assign w_cc_cnt[gi]  = r_cc_cnt;
      end
   endgenerate

   assign o_cc_err     = r_cc_err;
   assign o_pkt_cnt    = w_pkt_cnt[i_sel];
   assign o_cc_err_cnt = w_cc_cnt[i_sel];

endmodule
`default_nettype wire

// File: rtl/ts_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : ts_stream_checker
// Brief    : Frames 188-byte TS packets, reports lock, sync/length/CC errors.
// Revision : 1.0 - initial release
// ============================================================================
module ts_stream_checker
   import ts_pkg::*;
#(
   parameter logic [12:0] BASE_PID = 13'h1000,
   parameter int          CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [7:0]       DATA,
   input  logic             D_VALID,
   input  logic             P_SYNC,
   output logic             LOCK,
   output logic             PKT_DONE,
   output logic [12:0]      PKT_PID,
   output logic [1:0]       PKT_CH,
   output logic             PKT_KNOWN,
   output logic             SYNC_ERR,
   output logic             LEN_ERR,
   output logic             CC_ERR,
   input  logic [1:0]       CNT_SEL,
   output logic [CNT_W-1:0] PKT_CNT,
   output logic [CNT_W-1:0] CC_ERR_CNT,
   output logic [CNT_W-1:0] SYNC_ERR_CNT,
   output logic [CNT_W-1:0] LEN_ERR_CNT
);

   ts_state_t        r_state;
   logic [7:0]       r_idx;
   logic [12:0]      r_pid;
   logic             r_afc0;
   logic [3:0]       r_cc;
   logic             r_one_done;
   logic             r_lock;
   logic             r_pkt_done;
   logic             r_sync_err;
   logic             r_len_err;
   logic [12:0]      r_pkt_pid;
   logic [1:0]       r_pkt_ch;
   logic             r_pkt_known;
   logic [CNT_W-1:0] r_sync_err_cnt;
   logic [CNT_W-1:0] r_len_err_cnt;

   logic             w_sync_ok;
   logic             w_done;
   logic             w_sync_err;
   logic             w_len_err;
   logic             w_known;
   logic [12:0]      w_pid_off;

   assign w_sync_ok = (DATA == TS_SYNC_BYTE);
   assign w_pid_off = r_pid - BASE_PID;
   assign w_known   = (w_pid_off[12:2] == '0) && (r_pid != TS_NULL_PID);

   always_comb begin
      w_done     = 1'b0;
      w_sync_err = 1'b0;
      w_len_err  = 1'b0;
      if (D_VALID) begin
         case (r_state)
            HUNT: w_sync_err = P_SYNC && !w_sync_ok;
            IN_PKT: begin
               if (P_SYNC) begin
                  w_len_err  = 1'b1;
                  w_sync_err = !w_sync_ok;
               end else begin
                  w_done = (r_idx == TS_LAST_IDX);
               end
            end
            WAIT_SYNC: begin
               if (P_SYNC) w_sync_err = !w_sync_ok;
               else        w_len_err  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= HUNT;
         r_idx       <= '0;
         r_pid       <= '0;
         r_afc0      <= 1'b0;
         r_cc        <= '0;
         r_one_done  <= 1'b0;
         r_lock      <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_sync_err  <= 1'b0;
         r_len_err   <= 1'b0;
         r_pkt_pid   <= '0;
         r_pkt_ch    <= '0;
         r_pkt_known <= 1'b0;
      end else begin
         r_pkt_done <= w_done;
         r_sync_err <= w_sync_err;
         r_len_err  <= w_len_err;
         if (D_VALID) begin
            case (r_state)
               HUNT: begin
                  if (P_SYNC && w_sync_ok) begin
                     r_state <= IN_PKT;
                     r_idx   <= 8'd1;
                  end
               end
               IN_PKT: begin
                  if (P_SYNC) begin
                     r_idx <= 8'd1;
                     if (!w_sync_ok) r_state <= HUNT;
                  end else begin
                     case (r_idx)
                        8'd1: r_pid[12:8] <= DATA[4:0];
                        8'd2: r_pid[7:0]  <= DATA;
                        8'd3: begin
                           r_afc0 <= DATA[4];
                           r_cc   <= DATA[3:0];
                        end
                        default: ;
                     endcase
                     if (r_idx == TS_LAST_IDX) r_state <= WAIT_SYNC;
                     else                      r_idx   <= r_idx + 8'd1;
                  end
               end
               WAIT_SYNC: begin
                  r_idx   <= 8'd1;
                  r_state <= (P_SYNC && w_sync_ok) ? IN_PKT : HUNT;
               end
               default: r_state <= HUNT;
            endcase
         end
         if (w_done) begin
            r_pkt_pid   <= r_pid;
            r_pkt_ch    <= w_pid_off[1:0];
            r_pkt_known <= w_known;
         end
         // Lock needs two back-to-back good packets; any framing error restarts.
         if (w_sync_err || w_len_err) begin
            r_lock     <= 1'b0;
            r_one_done <= 1'b0;
         end else if (w_done) begin
            r_one_done <= 1'b1;
            if (r_one_done) r_lock <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync_err_cnt <= '0;
         r_len_err_cnt  <= '0;
      end else begin
         if (r_sync_err && (r_sync_err_cnt != '1)) r_sync_err_cnt <= r_sync_err_cnt + CNT_W'(1);
         if (r_len_err && (r_len_err_cnt != '1))   r_len_err_cnt  <= r_len_err_cnt + CNT_W'(1);
      end
   end

   ts_cc_tracker #(
      .CNT_W (CNT_W)
   ) u_cc_tracker (
      .clk          (CLK),
      .rst          (RST),
      .i_check      (w_done && w_known),
      .i_ch         (w_pid_off[1:0]),
      .i_afc0       (r_afc0),
      .i_cc         (r_cc),
      .i_sel        (CNT_SEL),
      .o_cc_err     (CC_ERR),
      .o_pkt_cnt    (PKT_CNT),
      .o_cc_err_cnt (CC_ERR_CNT)
   );

   assign LOCK         = r_lock;
   assign PKT_DONE     = r_pkt_done;
   assign PKT_PID      = r_pkt_pid;
   assign PKT_CH       = r_pkt_ch;
   assign PKT_KNOWN    = r_pkt_known;
   assign SYNC_ERR     = r_sync_err;
   assign LEN_ERR      = r_len_err;
   assign SYNC_ERR_CNT = r_sync_err_cnt;
   assign LEN_ERR_CNT  = r_len_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ts_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ts_stream_checker
// Brief    : Directed self-checking bench for ts_stream_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ts_stream_checker;

   localparam int CNT_W = 16;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [7:0]       DATA = '0;
   logic             D_VALID = 1'b0;
   logic             P_SYNC = 1'b0;
   logic [1:0]       CNT_SEL = '0;
   logic             LOCK, PKT_DONE, PKT_KNOWN, SYNC_ERR, LEN_ERR, CC_ERR;
   logic [12:0]      PKT_PID;
   logic [1:0]       PKT_CH;
   logic [CNT_W-1:0] PKT_CNT, CC_ERR_CNT, SYNC_ERR_CNT, LEN_ERR_CNT;

   int   n_vec = 0, n_bad = 0;
   int   n_done = 0, n_ccerr = 0, n_sync = 0, n_len = 0;
   logic last_done = 1'b0, last_cc = 1'b0, lock_at_err = 1'b1;

   ts_stream_checker #(.BASE_PID(13'h1000), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .DATA(DATA), .D_VALID(D_VALID), .P_SYNC(P_SYNC),
      .LOCK(LOCK), .PKT_DONE(PKT_DONE), .PKT_PID(PKT_PID), .PKT_CH(PKT_CH),
      .PKT_KNOWN(PKT_KNOWN), .SYNC_ERR(SYNC_ERR), .LEN_ERR(LEN_ERR), .CC_ERR(CC_ERR),
      .CNT_SEL(CNT_SEL), .PKT_CNT(PKT_CNT), .CC_ERR_CNT(CC_ERR_CNT),
      .SYNC_ERR_CNT(SYNC_ERR_CNT), .LEN_ERR_CNT(LEN_ERR_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled 1 ns after the edge and pulses tallied.
   task automatic cyc();
      @(posedge CLK);
      #1;
      last_done = PKT_DONE;
      last_cc   = CC_ERR;
      if (PKT_DONE) n_done++;
      if (CC_ERR)   n_ccerr++;
      if (SYNC_ERR) n_sync++;
      if (LEN_ERR) begin
         n_len++;
         lock_at_err = LOCK;
      end
   endtask

   task automatic idle();
      D_VALID = 1'b0;
      P_SYNC  = 1'b0;
      cyc();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      D_VALID = 1'b0;
      P_SYNC = 1'b0;
      cyc();
      cyc();
      RST = 1'b0;
      n_done = 0; n_ccerr = 0; n_sync = 0; n_len = 0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic ps);
      DATA = d;
      P_SYNC = ps;
      D_VALID = 1'b1;
      cyc();
      D_VALID = 1'b0;
      P_SYNC = 1'b0;
   endtask

   // Sends bytes 0..len-1 of a packet; optional random idle gaps before each byte.
   task automatic send_packet(input logic [12:0] pid, input logic [1:0] afc,
                              input logic [3:0] cc, input int len, input bit gaps);
      logic [7:0] d;
      for (int i = 0; i < len; i++) begin
         if (gaps)
            for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle();
         case (i)
            0:       d = 8'h47;
            1:       d = {3'b010, pid[12:8]};
            2:       d = pid[7:0];
            3:       d = {2'b00, afc, cc};
            default: d = 8'(i * 7 + 3);
         endcase
         send_byte(d, i == 0);
      end
   endtask

   task automatic run_clean(input bit gaps);
      for (int k = 0; k < 40; k++) begin
         send_packet(13'h1000 + 13'(k % 4), 2'b01, 4'(((k / 4) + 12) % 16), 188, gaps);
         if (k == 0) chk("lock_after_1st", LOCK, 0);
         if (k == 1) chk("lock_after_2nd", LOCK, 1);
      end
      chk("clean_done_count", n_done, 40);
      chk("clean_last_pid", PKT_PID, 13'h1003);
      chk("clean_last_ch", PKT_CH, 3);
      chk("clean_known", PKT_KNOWN, 1);
      chk("clean_lock", LOCK, 1);
      chk("clean_cc_pulses", n_ccerr, 0);
      idle();
      for (int s = 0; s < 4; s++) begin
         CNT_SEL = 2'(s);
         #1;
         chk($sformatf("pkt_cnt[%0d]", s), PKT_CNT, 10);
         chk($sformatf("cc_err_cnt[%0d]", s), CC_ERR_CNT, 0);
      end
      chk("clean_sync_cnt", SYNC_ERR_CNT, 0);
      chk("clean_len_cnt", LEN_ERR_CNT, 0);
   endtask

   initial begin
      int d0;

      // Reset state
      do_reset();
      chk("rst_lock", LOCK, 0);
      chk("rst_pkt_done", PKT_DONE, 0);
      chk("rst_pkt_pid", PKT_PID, 0);
      chk("rst_known", PKT_KNOWN, 0);
      chk("rst_pkt_cnt", PKT_CNT, 0);
      chk("rst_sync_cnt", SYNC_ERR_CNT, 0);

      // Clean gapless interleaved streams
      run_clean(1'b0);

      // Reset asserted at byte 50 of a packet
      send_packet(13'h1000, 2'b01, 4'd1, 50, 1'b0);
      DATA = 8'h33; D_VALID = 1'b1; RST = 1'b1;
      cyc();
      RST = 1'b0;
      CNT_SEL = 2'd0;
      #1;
      chk("midrst_lock", LOCK, 0);
      chk("midrst_pid", PKT_PID, 0);
      chk("midrst_known", PKT_KNOWN, 0);
      chk("midrst_pkt_cnt", PKT_CNT, 0);
      n_done = 0; n_ccerr = 0; n_sync = 0; n_len = 0;
      for (int i = 0; i < 5; i++) send_byte(8'(i + 60), 1'b0);
      chk("hunt_ignores_bytes", n_done + n_len + n_sync, 0);

      // Channel 2 CC sequence 4,5,7
      send_packet(13'h1002, 2'b01, 4'd4, 188, 1'b0);
      chk("cc4_done", last_done, 1);
      chk("cc4_ch", PKT_CH, 2);
      chk("cc4_lock", LOCK, 0);
      send_packet(13'h1002, 2'b01, 4'd5, 188, 1'b0);
      chk("cc5_no_err", last_cc, 0);
      chk("cc5_lock", LOCK, 1);
      send_packet(13'h1002, 2'b01, 4'd7, 188, 1'b0);
      chk("cc7_done", last_done, 1);
      chk("cc7_cc_err", last_cc, 1);
      chk("cc7_lock", LOCK, 1);
      idle();
      CNT_SEL = 2'd2;
      #1;
      chk("ch2_cc_err_cnt", CC_ERR_CNT, 1);
      chk("ch2_pkt_cnt", PKT_CNT, 3);

      // Channel 0: first packet records, AFC without payload repeats CC
      send_packet(13'h1000, 2'b01, 4'd9, 188, 1'b0);
      chk("ch0_first_no_err", last_cc, 0);
      send_packet(13'h1000, 2'b10, 4'd9, 188, 1'b0);
      chk("ch0_afc_hold_ok", last_cc, 0);
      send_packet(13'h1000, 2'b10, 4'd10, 188, 1'b0);
      chk("ch0_afc_hold_err", last_cc, 1);
      send_packet(13'h1FFF, 2'b01, 4'd3, 188, 1'b0);
      chk("null_done", last_done, 1);
      chk("null_pid", PKT_PID, 13'h1FFF);
      chk("null_known", PKT_KNOWN, 0);
      chk("null_no_cc", last_cc, 0);
      idle();
      CNT_SEL = 2'd0;
      #1;
      chk("ch0_pkt_cnt", PKT_CNT, 3);
      chk("ch0_cc_err_cnt", CC_ERR_CNT, 1);
      chk("total_cc_pulses", n_ccerr, 2);

      // Early P_SYNC at byte index 100
      d0 = n_done;
      send_packet(13'h1001, 2'b01, 4'd8, 100, 1'b0);
      send_packet(13'h1001, 2'b01, 4'd3, 188, 1'b0);
      chk("len_pulses", n_len, 1);
      chk("len_lock_drop", lock_at_err, 0);
      chk("len_one_done", n_done - d0, 1);
      chk("len_restart_done", last_done, 1);
      chk("len_restart_pid", PKT_PID, 13'h1001);
      chk("len_lock_after", LOCK, 0);
      chk("len_restart_no_cc", last_cc, 0);
      idle();
      chk("len_err_cnt_1", LEN_ERR_CNT, 1);

      // WAIT_SYNC byte without P_SYNC, then combined sync+length error
      send_packet(13'h1001, 2'b01, 4'd4, 188, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("wait_len_err", LEN_ERR, 1);
      chk("wait_no_sync_err", SYNC_ERR, 0);
      send_packet(13'h1001, 2'b01, 4'd5, 10, 1'b0);
      send_byte(8'h46, 1'b1);
      chk("both_sync_err", SYNC_ERR, 1);
      chk("both_len_err", LEN_ERR, 1);
      idle();
      chk("len_err_cnt_3", LEN_ERR_CNT, 3);
      chk("sync_err_cnt_1", SYNC_ERR_CNT, 1);

      // Bad sync byte from HUNT
      do_reset();
      send_byte(8'h46, 1'b1);
      chk("hunt_sync_err", SYNC_ERR, 1);
      chk("hunt_no_len_err", LEN_ERR, 0);
      send_byte(8'h12, 1'b0);
      chk("hunt_stays", LEN_ERR, 0);
      idle();
      chk("hunt_sync_cnt", SYNC_ERR_CNT, 1);
      chk("hunt_len_cnt", LEN_ERR_CNT, 0);
      send_packet(13'h1003, 2'b01, 4'd0, 188, 1'b0);
      chk("hunt_recover_done", last_done, 1);
      chk("hunt_recover_ch", PKT_CH, 3);

      // Clean streams with random D_VALID gaps
      do_reset();
      run_clean(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
